booth_seq_mult: RTL and testbench

- Parametrised sequential Booth multiplier with datapath and control FSM in one block.
- Multiplies two WIDTH-bit operands, signed or unsigned, selected per operation.
- start/busy/done handshake; fixed, data-independent latency.
- Drop-in arithmetic unit for the datapath; the successor to the fixed-width radix-2 controller plus separate datapath.

---
 rtl/booth_pkg.sv | 25 ++
 rtl/booth_seq_mult_recoder.sv | 23 ++
 rtl/booth_seq_mult.sv | 156 +++++++++++++++
 tb/tb_booth_seq_mult.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM states,
// radix-4 digit encodings and the iteration-count helper.
package booth_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ARITH = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Digit encoding: bit2 = negate, bit1 = use 2M, bit0 = use 1M.
    localparam logic [2:0] ZERO = 3'b000;
    localparam logic [2:0] P1   = 3'b001;
    localparam logic [2:0] P2   = 3'b010;
    localparam logic [2:0] M1   = 3'b101;
    localparam logic [2:0] M2   = 3'b110;

    // Number of ARITH/SHIFT passes needed to consume the extended multiplier.
    function automatic int booth_iter(input int width, input bit radix4);
        return radix4 ? (width / 2 + 1) : (width + 1);
    endfunction

endpackage

// File: rtl/booth_seq_mult_recoder.sv
// Booth recoder: maps a {q[i+1], q[i], q[i-1]} bit group to a signed digit.
// The radix-2 datapath feeds {Q[0], Q[0], q_m1}, which only ever yields
// ZERO, P1 or M1, so one table serves both radices.
module booth_recoder
    import booth_pkg::*;
(
    input  logic [2:0] grp,
    output logic [2:0] digit
);

    // Standard modified-Booth recoding table.
    always_comb begin
        digit = ZERO;
        case (grp)
            3'b001, 3'b010: digit = P1;
            3'b011:         digit = P2;
            3'b100:         digit = M2;
            3'b101, 3'b110: digit = M1;
            default:        digit = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential Booth multiplier, signed or unsigned per operation, with a
// start/busy/done handshake and fixed latency of 2*ITER+2 cycles.
// Optional build macro: BOOTH_RADIX4_EN selects radix-4 recoding
// (shift by 2, ITER = WIDTH/2+1); otherwise radix-2 (ITER = WIDTH+1).
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

`ifdef BOOTH_RADIX4_EN
    localparam bit RADIX4 = 1'b1;
`else
    localparam bit RADIX4 = 1'b0;
`endif

    localparam int ITER = booth_iter(WIDTH, RADIX4);
    localparam int QW   = WIDTH + 2;
    // A +/- 2M can exceed WIDTH+2 bits before the shift brings it back into
    // range, so the radix-4 accumulator carries one guard bit.
    localparam int AW   = RADIX4 ? WIDTH + 3 : WIDTH + 2;
    localparam int SH   = RADIX4 ? 2 : 1;
    // Radix-2 never consumes the top (sign-extension) multiplier bit, so the
    // finished product sits one position higher in {A,Q}.
    localparam int PLSB = RADIX4 ? 1 : 2;
    localparam logic [CNT_W-1:0] ITER_C = CNT_W'(ITER);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("booth_seq_mult: WIDTH must be in 2..32");
    end
    if (RADIX4 && (WIDTH % 2 != 0)) begin : g_odd_width
        $error("booth_seq_mult: radix-4 build requires an even WIDTH");
    end

    state_t               state_reg, state_next;
    logic [AW-1:0]        a_reg, m_reg;
    logic [QW-1:0]        q_reg;
    logic                 qm1_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 busy_reg, busy_next;
    logic                 done_reg, done_next;
    logic [2*WIDTH-1:0]   product_reg;
    logic                 prod_load;

    logic                 accept;
    logic [AW-1:0]        ext_m;
    logic [QW-1:0]        ext_q;
    logic [2:0]           grp;
    logic [2:0]           digit;
    logic [AW-1:0]        m_sel;
    logic [AW-1:0]        a_arith;
    logic signed [AW+QW:0] shifted;
    logic [AW-1:0]        a_sh;
    logic [QW-1:0]        q_sh;
    logic                 qm1_sh;
    logic [2*WIDTH-1:0]   product_sh;

    assign accept = start && (state_reg == IDLE || state_reg == DONE);
    assign ext_m  = {{(AW-WIDTH){multiplicand[WIDTH-1] & is_signed}}, multiplicand};
    assign ext_q  = {{(QW-WIDTH){multiplier[WIDTH-1] & is_signed}}, multiplier};

    assign grp = RADIX4 ? {q_reg[1], q_reg[0], qm1_reg} : {q_reg[0], q_reg[0], qm1_reg};

    booth_recoder u_recoder (
        .grp   (grp),
        .digit (digit)
    );

    assign m_sel   = digit[1] ? (m_reg << 1) : m_reg;
    assign a_arith = (digit[1] | digit[0]) ? (digit[2] ? a_reg - m_sel : a_reg + m_sel) : a_reg;

    assign shifted    = $signed({a_reg, q_reg, qm1_reg}) >>> SH;
    assign a_sh       = shifted[AW+QW:QW+1];
    assign q_sh       = shifted[QW:1];
    assign qm1_sh     = shifted[0];
    assign product_sh = shifted[PLSB +: 2*WIDTH];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic; unknown encodings fall back to IDLE.
    always_comb begin
        state_next = IDLE;
        case (state_reg)
            IDLE:    state_next = start ? LOAD : IDLE;
            LOAD:    state_next = ARITH;
            ARITH:   state_next = SHIFT;
            SHIFT:   state_next = (cnt_reg == CNT_W'(1)) ? DONE : ARITH;
            DONE:    state_next = start ? LOAD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the outputs can be registered.
    always_comb begin
        busy_next = (state_next == LOAD) || (state_next == ARITH) || (state_next == SHIFT);
        done_next = (state_next == DONE);
        prod_load = (state_reg == SHIFT) && (state_next == DONE);
    end

    // Registered handshake outputs and held product.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            product_reg <= '0;
        end else begin
            busy_reg <= busy_next;
            done_reg <= done_next;
            if (prod_load) product_reg <= product_sh;
        end
    end

    // Datapath: operands captured on the accepting edge, then add/shift passes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg   <= '0;
            m_reg   <= '0;
            q_reg   <= '0;
            qm1_reg <= 1'b0;
            cnt_reg <= '0;
        end else if (accept) begin
            a_reg   <= '0;
            m_reg   <= ext_m;
            q_reg   <= ext_q;
            qm1_reg <= 1'b0;
            cnt_reg <= ITER_C;
        end else if (state_reg == ARITH) begin
            a_reg <= a_arith;
        end else if (state_reg == SHIFT) begin
            a_reg   <= a_sh;
            q_reg   <= q_sh;
            qm1_reg <= qm1_sh;
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign product = product_reg;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult (WIDTH=8). Builds for either radix
// via BOOTH_RADIX4_EN. Expected products come from a table or a plain
// multiply; a scoreboard predicts acceptance, busy, done timing and the
// held product every cycle.
module tb_booth_seq_mult;

    localparam int W = 8;
`ifdef BOOTH_RADIX4_EN
    localparam int ITER = W / 2 + 1;
`else
    localparam int ITER = W + 1;
`endif
    localparam int LAT = 2 * ITER + 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           is_signed = 1'b0;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic           busy, done;
    logic [2*W-1:0] product;

    booth_seq_mult #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .is_signed    (is_signed),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] prod;
        int             done_edge;
    } sb_t;

    typedef struct {
        logic           s;
        logic [W-1:0]   m;
        logic [W-1:0]   q;
        logic [2*W-1:0] prod;
    } vec_t;

    sb_t            sb_q[$];
    int             edge_cnt = 0;
    int             next_free = 0;
    int             accept_cnt = 0;
    int             last_done_edge = 0;
    int             prev_done_edge = 0;
    logic [2*W-1:0] drive_exp = '0;
    logic [2*W-1:0] prod_model = '0;
    int             n_checks = 0;
    int             n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, edge_cnt);
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic s, input logic [W-1:0] m, input logic [W-1:0] q);
        logic signed [2*W-1:0] sm, sq;
        if (s) begin
            sm = {{W{m[W-1]}}, m};
            sq = {{W{q[W-1]}}, q};
            return sm * sq;
        end
        return {{W{1'b0}}, m} * {{W{1'b0}}, q};
    endfunction

    // Scoreboard: predict acceptance at the edge, then check outputs just after it.
    always @(posedge clk) begin
        logic exp_done, exp_busy;
        edge_cnt++;
        if (!rst_n) begin
            sb_q.delete();
            prod_model = '0;
            next_free  = edge_cnt + 1;
        end else if (start && edge_cnt >= next_free) begin
            sb_q.push_back('{prod: drive_exp, done_edge: edge_cnt + LAT - 1});
            next_free = edge_cnt + LAT;
            accept_cnt++;
        end
        #1;
        exp_done = (sb_q.size() > 0) && (sb_q[0].done_edge == edge_cnt);
        exp_busy = (sb_q.size() > 0) && (edge_cnt < sb_q[0].done_edge);
        if (exp_done) begin
            prod_model = sb_q[0].prod;
            void'(sb_q.pop_front());
            prev_done_edge = last_done_edge;
            last_done_edge = edge_cnt;
            $display("done at edge %0d: product %0h expected %0h", edge_cnt, product, prod_model);
        end
        chk("done", {31'd0, done}, {31'd0, exp_done});
        chk("busy", {31'd0, busy}, {31'd0, exp_busy});
        chk("product", {16'd0, product}, {16'd0, prod_model});
    end

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (sb_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", sb_q.size(), 0);
    endtask

    task automatic wait_accepts(input int target, input int max_cyc);
        int n = 0;
        while (accept_cnt < target && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("wait_accept", accept_cnt, target);
    endtask

    task automatic drive_op(input logic s, input logic [W-1:0] m, input logic [W-1:0] q, input logic [2*W-1:0] e);
        @(negedge clk);
        is_signed    = s;
        multiplicand = m;
        multiplier   = q;
        drive_exp    = e;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
        is_signed    = ~s;
    endtask

    task automatic run_op(input logic s, input logic [W-1:0] m, input logic [W-1:0] q, input logic [2*W-1:0] e);
        drive_op(s, m, q, e);
        wait_idle(LAT + 10);
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{s: 1'b1, m: 8'hF9, q: 8'h03, prod: 16'hFFEB};
        tbl[1] = '{s: 1'b1, m: 8'h80, q: 8'h80, prod: 16'h4000};
        tbl[2] = '{s: 1'b0, m: 8'hFF, q: 8'hFF, prod: 16'hFE01};
        tbl[3] = '{s: 1'b1, m: 8'hFF, q: 8'hFF, prod: 16'h0001};
        tbl[4] = '{s: 1'b1, m: 8'h7F, q: 8'h80, prod: 16'hC080};
        tbl[5] = '{s: 1'b1, m: 8'h7F, q: 8'h7F, prod: 16'h3F01};
        tbl[6] = '{s: 1'b0, m: 8'h12, q: 8'h34, prod: 16'h03A8};
        tbl[7] = '{s: 1'b1, m: 8'h85, q: 8'h06, prod: 16'hFD1E};

        // Reset held for a few cycles; the monitor checks the cleared outputs.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_op(tbl[i].s, tbl[i].m, tbl[i].q, tbl[i].prod);

        // Start while busy must be ignored.
        drive_op(1'b1, 8'hF9, 8'h03, 16'hFFEB);
        repeat (3) @(negedge clk);
        multiplicand = 8'h55;
        multiplier   = 8'h55;
        is_signed    = 1'b0;
        drive_exp    = 16'h1C39;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        wait_idle(LAT + 10);

        // Reset mid-operation, then a fresh operation completes.
        drive_op(1'b0, 8'hFF, 8'hFF, 16'hFE01);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b1, 8'h80, 8'h80, 16'h4000);

        // Reset asserted together with start: reset wins.
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        multiplicand = 8'h10;
        multiplier   = 8'h10;
        drive_exp    = 16'h0100;
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // start held high: two back-to-back operations via DONE -> LOAD.
        begin
            int a0;
            a0 = accept_cnt;
            @(negedge clk);
            is_signed    = 1'b1;
            multiplicand = 8'hF9;
            multiplier   = 8'h03;
            drive_exp    = 16'hFFEB;
            start        = 1'b1;
            wait_accepts(a0 + 1, 5);
            is_signed    = 1'b0;
            multiplicand = 8'hFF;
            multiplier   = 8'hFF;
            drive_exp    = 16'hFE01;
            wait_accepts(a0 + 2, LAT + 10);
            start = 1'b0;
            wait_idle(LAT + 10);
            chk("b2b_gap", last_done_edge - prev_done_edge, LAT);
        end

        // Randomised sweep against a plain multiply.
        for (int i = 0; i < 400; i++) begin
            logic           s;
            logic [W-1:0]   m, q;
            s = 1'($urandom_range(0, 1));
            m = W'($urandom);
            q = W'($urandom);
            run_op(s, m, q, ref_mul(s, m, q));
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
